cs_tb_test_ctrl: RTL

//  Test-lifecycle controller for the CS-register bench; sits downstream of the DPI env tick.

---
 rtl/cs_tb_ctrl_pkg.sv | 29 ++
 rtl/cs_tb_outstanding_cnt.sv | 39 +++
 rtl/cs_tb_test_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cs_tb_ctrl_pkg.sv
// cs_tb_ctrl_pkg: shared types for the CS-register bench test controller.
// Holds the lifecycle states, the verdict codes reported on result_o and
// a small helper that turns the latched pass flag into a verdict.
package cs_tb_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_INIT = 3'd1,
        ST_INIT      = 3'd2,
        ST_RUN       = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_DONE      = 3'd5
    } cs_tb_state_e;

    typedef enum logic [2:0] {
        RES_NONE      = 3'd0,
        RES_PASS      = 3'd1,
        RES_FAIL      = 3'd2,
        RES_DRAIN_TO  = 3'd3,
        RES_OVERFLOW  = 3'd4,
        RES_UNDERFLOW = 3'd5,
        RES_WATCHDOG  = 3'd6
    } cs_tb_result_e;

    function automatic cs_tb_result_e verdict_of(input logic pass);
        return pass ? RES_PASS : RES_FAIL;
    endfunction

endpackage

// File: rtl/cs_tb_outstanding_cnt.sv
// cs_tb_outstanding_cnt: in-flight CSR transaction counter.
// Counts accepted requests up and returned responses down; simultaneous
// request and response cancel. A step past zero or past MaxCount is
// refused (the count holds) and reported on underflow/overflow.
module cs_tb_outstanding_cnt #(
    parameter int MaxCount = 8,
    parameter int CountW   = $clog2(MaxCount + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [CountW-1:0] count,
    output logic              overflow,
    output logic              underflow
);

    logic [CountW-1:0] count_q;

    // Flag an attempted step past either end before it would be applied
    always_comb begin
        overflow  = inc && !dec && (count_q == CountW'(MaxCount));
        underflow = dec && !inc && (count_q == '0);
    end

    // Apply the net up/down step; an illegal step leaves the count as it was
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && !dec && !overflow) begin
            count_q <= count_q + CountW'(1);
        end else if (dec && !inc && !underflow) begin
            count_q <= count_q - CountW'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cs_tb_test_ctrl.sv
// cs_tb_test_ctrl: test-lifecycle controller for the CS-register bench.
// Sequences reset -> wait -> init -> run -> drain -> done, gates the env
// tick, tracks in-flight CSR transactions and latches the final verdict.
// Build option: define CS_TB_WATCHDOG_EN to end the test with RES_WATCHDOG
// once RUN has lasted WatchdogCycles cycles without a stop request.
module cs_tb_test_ctrl
    import cs_tb_ctrl_pkg::*;
#(
    parameter int InitDelay      = 4,
    parameter int MaxOutstanding = 8,
    parameter int DrainTimeout   = 64,
    parameter int WatchdogCycles = 100000,
    parameter int CycleW         = 32,
    parameter int OutstandingW   = $clog2(MaxOutstanding + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    output logic                    init_o,
    output logic                    tick_en_o,
    input  logic                    stop_req_i,
    input  logic                    test_passed_i,
    output logic                    issue_en_o,
    input  logic                    req_fire_i,
    input  logic                    rsp_fire_i,
    output logic [OutstandingW-1:0] outstanding_o,
    output logic [CycleW-1:0]       cycle_count_o,
    output logic                    done_o,
    output logic                    passed_o,
    output logic [2:0]              result_o
);

    localparam int DelayW = $clog2(InitDelay + 1);
    localparam int DrainW = $clog2(DrainTimeout + 1);

    cs_tb_state_e      state_q, state_d;
    cs_tb_result_e     result_q, result_d;
    logic              pass_q, pass_d;
    logic [DelayW-1:0] delay_cnt_q, delay_cnt_d;
    logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
    logic [CycleW-1:0] cycle_cnt_q, cycle_cnt_d;

    logic [OutstandingW-1:0] outstanding;
    logic                    overflow;
    logic                    underflow;
    logic                    watchdog_hit;

    cs_tb_outstanding_cnt #(
        .MaxCount (MaxOutstanding),
        .CountW   (OutstandingW)
    ) u_outstanding (
        .clk       (clk_i),
        .rst       (rst_i),
        .inc       (req_fire_i),
        .dec       (rsp_fire_i),
        .count     (outstanding),
        .overflow  (overflow),
        .underflow (underflow)
    );

`ifdef CS_TB_WATCHDOG_EN
    assign watchdog_hit = (cycle_cnt_q >= CycleW'(WatchdogCycles));
`else
    localparam int unused_watchdog_cycles = WatchdogCycles;
    assign watchdog_hit = 1'b0;
`endif

    // Lifecycle register bank: state, delay/drain counters, run-cycle count and verdict
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_RESET;
            result_q    <= RES_NONE;
            pass_q      <= 1'b0;
            delay_cnt_q <= '0;
            drain_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            pass_q      <= pass_d;
            delay_cnt_q <= delay_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    // Next-state logic; a counter error in any live state wins over everything else
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        pass_d      = pass_q;
        delay_cnt_d = delay_cnt_q;
        drain_cnt_d = drain_cnt_q;
        cycle_cnt_d = cycle_cnt_q;

        case (state_q)
            ST_RESET: begin
                delay_cnt_d = '0;
                state_d     = ST_WAIT_INIT;
            end
            ST_WAIT_INIT: begin
                if (delay_cnt_q == DelayW'(InitDelay - 1)) begin
                    state_d = ST_INIT;
                end else begin
                    delay_cnt_d = delay_cnt_q + DelayW'(1);
                end
            end
            ST_INIT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cycle_cnt_q != '1) begin
                    cycle_cnt_d = cycle_cnt_q + CycleW'(1);
                end
                if (watchdog_hit) begin
                    state_d  = ST_DONE;
                    result_d = RES_WATCHDOG;
                end else if (stop_req_i) begin
                    pass_d      = test_passed_i;
                    drain_cnt_d = '0;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (outstanding == '0) begin
                    state_d  = ST_DONE;
                    result_d = verdict_of(pass_q);
                end else if (drain_cnt_q == DrainW'(DrainTimeout - 1)) begin
                    state_d  = ST_DONE;
                    result_d = RES_DRAIN_TO;
                end else begin
                    drain_cnt_d = drain_cnt_q + DrainW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        if ((state_q != ST_DONE) && (overflow || underflow)) begin
            state_d  = ST_DONE;
            result_d = overflow ? RES_OVERFLOW : RES_UNDERFLOW;
        end
    end

    assign init_o        = (state_q == ST_INIT);
    assign tick_en_o     = (state_q == ST_RUN);
    assign issue_en_o    = (state_q == ST_RUN);
    assign done_o        = (state_q == ST_DONE);
    assign passed_o      = (state_q == ST_DONE) && (result_q == RES_PASS);
    assign result_o      = result_q;
    assign outstanding_o = outstanding;
    assign cycle_count_o = cycle_cnt_q;

endmodule
